// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store stage in front of DataMemory with partial-store read-modify-write
module load_store_unit #(
    parameter int BASE_WORD = 256,
    parameter int TOP_WORD  = 1023
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Ready,
    output logic        Done,
    output logic        Err,
    output logic [31:0] RData,
    output logic        Mem_We,
    output logic [9:0]  Mem_Addr,
    output logic [31:0] Mem_Din,
    input  logic [31:0] Mem_Dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LDCAP = 3'd2,
        MERGE = 3'd3,
        WR    = 3'd4
    } state_t;

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [10:0] BASE_W  = 11'(BASE_WORD);
    localparam logic [10:0] TOP_W   = 11'(TOP_WORD);

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [9:0]  mem_addr_q, mem_addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] wdata_q, wdata_d;
    logic        load_q, load_d;

    logic        req_err;
    logic [10:0] word_idx;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Every rejection is decided from the raw request so a bad access never reaches memory.
    always_comb begin
        word_idx = {1'b0, Addr[11:2]};
        req_err  = (MemRead == MemWrite)
                || (Size == 2'b11)
                || (Size == SZ_HALF && Addr[0])
                || (Size == SZ_WORD && Addr[1:0] != 2'b00)
                || (Addr[31:12] != 20'd0)
                || (word_idx < BASE_W)
                || (word_idx > TOP_W);
    end

    always_comb begin
        lane_byte = Mem_Dout[{lane_q, 3'b000} +: 8];
        lane_half = lane_q[1] ? Mem_Dout[31:16] : Mem_Dout[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_val = {{16{sext_q & lane_half[15]}}, lane_half};
            default: load_val = Mem_Dout;
        endcase
    end

    always_comb begin
        merged = Mem_Dout;
        if (size_q == SZ_BYTE) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (size_q == SZ_HALF) begin
            if (lane_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        lane_d     = lane_q;
        size_d     = size_q;
        sext_d     = sext_q;
        wdata_d    = wdata_q;
        load_d     = load_q;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    if (req_err) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        mem_addr_d = Addr[11:2];
                        lane_d     = Addr[1:0];
                        size_d     = Size;
                        sext_d     = SignExt;
                        wdata_d    = WData;
                        load_d     = MemRead;
                        // Only full-word stores can skip the read half of the access.
                        state_d    = (MemWrite && Size == SZ_WORD) ? WR : RD;
                    end
                end
            end
            RD:    state_d = load_q ? LDCAP : MERGE;
            LDCAP: begin
                rdata_d = load_val;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            MERGE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            WR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            mem_addr_q <= 10'd0;
            lane_q     <= 2'd0;
            size_q     <= 2'd0;
            sext_q     <= 1'b0;
            wdata_q    <= 32'd0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            wdata_q    <= wdata_d;
            load_q     <= load_d;
        end
    end

    // Write enable comes straight from state so an async reset kills it in the same cycle.
    assign Ready    = (state_q == IDLE);
    assign Mem_We   = (state_q == WR) || (state_q == MERGE);
    assign Mem_Din  = (state_q == MERGE) ? merged : wdata_q;
    assign Mem_Addr = mem_addr_q;
    assign Done     = done_q;
    assign Err      = err_q;
    assign RData    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Req = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        SignExt = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WData = 32'd0;
    logic        Ready, Done, Err, Mem_We;
    logic [31:0] RData, Mem_Din;
    logic [9:0]  Mem_Addr;
    logic [31:0] Mem_Dout = 32'd0;

    load_store_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .SignExt(SignExt), .Addr(Addr), .WData(WData),
        .Ready(Ready), .Done(Done), .Err(Err), .RData(RData),
        .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Din(Mem_Din), .Mem_Dout(Mem_Dout)
    );

    always #5 Clk = ~Clk;

    // DataMemory stand-in: synchronous write, registered read when not writing.
    logic [31:0] dm [0:1023];
    always @(posedge Clk) begin
        if (Mem_We === 1'b1) dm[Mem_Addr] <= Mem_Din;
        else                 Mem_Dout <= dm[Mem_Addr];
    end

    int          we_cnt = 0;
    logic [31:0] last_din = 32'd0;
    always @(negedge Clk) begin
        if (Mem_We === 1'b1) begin
            we_cnt   <= we_cnt + 1;
            last_din <= Mem_Din;
        end
    end

    int          total = 0;
    int          bad = 0;
    logic [7:0]  ref_b [0:4095];
    logic [31:0] exp_rdata = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic rd, input logic wr, input logic [1:0] sz,
                                     input logic [31:0] a);
        if (rd == wr || sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && a % 2 != 0) return 1'b1;
        if (sz == 2'd2 && a % 4 != 0) return 1'b1;
        return (a < 32'h400) || (a >= 32'h1000);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_b[a[11:0] + 12'(i)]) << (8 * i));
        if (sx && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_b[a[11:0] + 12'(i)] = 8'(wd >> (8 * i));
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic e;
        int n, we0, lat;
        e = ref_err(rd, wr, sz, a);
        lat = e ? 0 : ((wr && sz == 2'd2) ? 1 : 2);
        @(negedge Clk);
        MemRead = rd; MemWrite = wr; Size = sz; SignExt = sx; Addr = a; WData = wd; Req = 1'b1;
        n = 0;
        while (Ready !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
        check_eq({tag, "_ready"}, 32'(Ready), 32'd1);
        we0 = we_cnt;
        @(posedge Clk);
        @(negedge Clk);
        Req = 1'b0;
        n = 0;
        while (Done !== 1'b1 && n < 8) begin @(negedge Clk); n++; end
        check_eq({tag, "_done"}, 32'(Done), 32'd1);
        check_eq({tag, "_lat"}, 32'(n), 32'(lat));
        check_eq({tag, "_err"}, 32'(Err), 32'(e));
        if (!e && rd) exp_rdata = ref_load(sz, sx, a);
        if (!e && wr) ref_store(sz, a, wd);
        check_eq({tag, "_rdata"}, RData, exp_rdata);
        check_eq({tag, "_we"}, 32'(we_cnt - we0), (!e && wr) ? 32'd1 : 32'd0);
        @(negedge Clk);
        check_eq({tag, "_pulse"}, 32'({Done, Err}), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [4:0]  dpat;
        logic [1:0]  sz;
        logic        rd, wr;
        logic [31:0] a;
        int          r;

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (i == 256) w = 32'h000007D1;
            if (i == 257) w = 32'h00000FA1;
            if (i == 258) w = 32'h00001389;
            dm[i] <= w;
            for (int k = 0; k < 4; k++) ref_b[i * 4 + k] = w[8 * k +: 8];
        end

        #2;
        check_eq("rst_ready", 32'(Ready), 32'd1);
        check_eq("rst_flags", 32'({Done, Err, Mem_We}), 32'd0);
        check_eq("rst_rdata", RData, 32'd0);
        check_eq("rst_maddr", 32'(Mem_Addr), 32'd0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;

        txn(1, 0, 2'd2, 0, 32'h400, 0, "lw_400");
        txn(0, 1, 2'd2, 0, 32'h400, 32'h123480FF, "sw_400");
        txn(1, 0, 2'd0, 1, 32'h400, 0, "lb_400");
        check_eq("lb_400_val", RData, 32'hFFFFFFFF);
        txn(1, 0, 2'd0, 0, 32'h401, 0, "lbu_401");
        check_eq("lbu_401_val", RData, 32'h00000080);
        txn(1, 0, 2'd1, 1, 32'h402, 0, "lh_402");
        check_eq("lh_402_val", RData, 32'h00001234);
        txn(1, 0, 2'd1, 1, 32'h400, 0, "lh_400");
        check_eq("lh_400_val", RData, 32'hFFFF80FF);

        txn(0, 1, 2'd0, 0, 32'h405, 32'h000000AA, "sb_405");
        check_eq("sb_405_din", last_din, 32'h0000AAA1);
        txn(1, 0, 2'd2, 0, 32'h404, 0, "lw_404");
        check_eq("lw_404_val", RData, 32'h0000AAA1);

        txn(1, 0, 2'd2, 0, 32'h402, 0, "err_lw402");
        txn(1, 0, 2'd1, 0, 32'h401, 0, "err_lh401");
        txn(1, 0, 2'd2, 0, 32'h3FC, 0, "err_lw3fc");
        txn(1, 0, 2'd2, 0, 32'h1000, 0, "err_lw1000");
        txn(1, 0, 2'd3, 0, 32'h400, 0, "err_size3");
        check_eq("err_keep_rdata", RData, 32'h0000AAA1);

        // Reset in the MERGE cycle must abort before the write edge.
        @(negedge Clk);
        MemRead = 0; MemWrite = 1; Size = 2'd1; SignExt = 0; Addr = 32'h408; WData = 32'h0000BEEF; Req = 1;
        @(posedge Clk);
        @(negedge Clk);
        Req = 0;
        @(negedge Clk);
        check_eq("rst_merge_we_before", 32'(Mem_We), 32'd1);
        Rst_n = 1'b0;
        #1;
        check_eq("rst_merge_we", 32'(Mem_We), 32'd0);
        check_eq("rst_merge_flags", 32'({Done, Err}), 32'd0);
        check_eq("rst_merge_ready", 32'(Ready), 32'd1);
        exp_rdata = 32'd0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_eq("rst_merge_done", 32'({Done, Err}), 32'd0);
        txn(1, 0, 2'd2, 0, 32'h408, 0, "lw_408");
        check_eq("lw_408_val", RData, 32'h00001389);

        // Back-to-back: SW presented while LW is busy, accepted in the LW Done cycle.
        @(negedge Clk);
        MemRead = 1; MemWrite = 0; Size = 2'd2; SignExt = 0; Addr = 32'h40C; WData = 0; Req = 1;
        @(posedge Clk);
        @(negedge Clk);
        MemRead = 0; MemWrite = 1; Addr = 32'h410; WData = 32'hCAFEF00D;
        dpat = 5'd0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge Clk);
            dpat[k] = Done;
            if (k == 2) check_eq("b2b_lw_rdata", RData, ref_load(2'd2, 0, 32'h40C));
            if (k == 3) Req = 0;
            if (k == 4) check_eq("b2b_sw_err", 32'(Err), 32'd0);
        end
        check_eq("b2b_done_pattern", 32'(dpat), 32'b10100);
        exp_rdata = ref_load(2'd2, 0, 32'h40C);
        ref_store(2'd2, 32'h410, 32'hCAFEF00D);
        @(negedge Clk);
        check_eq("b2b_pulse", 32'(Done), 32'd0);
        txn(1, 0, 2'd2, 0, 32'h410, 0, "lw_410");

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'h400 + $urandom_range(0, 63);
            else if (r == 7) a = $urandom_range(0, 32'h3FF);
            else if (r == 8) a = 32'hFFC + $urandom_range(0, 7);
            else             a = $urandom;
            r = $urandom_range(0, 9);
            rd = (r == 1) || (r >= 2 && r < 6);
            wr = (r == 1) || (r >= 6);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            txn(rd, wr, sz, 1'($urandom), a, $urandom, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
